// File: rtl/int_to_fpu_if.sv
// Handshake and result bus between a requester and the int_to_fpu encoder.
// The requester drives start/int_in; the encoder returns busy/done and the encoded result.
interface int_to_fpu_if;
  logic        start;
  logic [31:0] int_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  modport master (
    output start,
    output int_in,
    input  busy,
    input  done,
    input  data_out,
    input  status_out
  );

  modport slave (
    input  start,
    input  int_in,
    output busy,
    output done,
    output data_out,
    output status_out
  );
endinterface

// File: rtl/int_to_fpu.sv
// Signed 32-bit integer to {sign, exp[5:0], mant[24:0]} float encoder.
// Normalises one bit per clock, then rounds to nearest with ties away from zero.
module int_to_fpu #(
  parameter int BIAS = 31
) (
  input  logic        clock100KHz,
  input  logic        reset,
  int_to_fpu_if.slave bus
);

  localparam logic [3:0] STATUS_EXACT   = 4'b0001;
  localparam logic [3:0] STATUS_INEXACT = 4'b0010;
  localparam logic [5:0] EXP_START      = 6'(BIAS + 31);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t      state_reg;
  logic        sign_reg;
  logic [31:0] mag_reg;
  logic [5:0]  exp_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [31:0] data_reg;
  logic [3:0]  status_reg;

  logic [25:0] round_sum;
  logic        sticky;
  logic [5:0]  exp_round;

  // Guard bit alone decides the increment; a carry out of the mantissa bumps the exponent.
  always_comb begin
    round_sum = {1'b0, mag_reg[30:6]} + {25'd0, mag_reg[5]};
    sticky    = |mag_reg[4:0];
    exp_round = exp_reg + {5'd0, round_sum[25]};
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      sign_reg   <= 1'b0;
      mag_reg    <= 32'd0;
      exp_reg    <= 6'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      data_reg   <= 32'd0;
      status_reg <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            busy_reg <= 1'b1;
            if (bus.int_in == 32'd0) begin
              data_reg   <= 32'd0;
              status_reg <= STATUS_EXACT;
              done_reg   <= 1'b1;
              state_reg  <= DONE;
            end else begin
              sign_reg  <= bus.int_in[31];
              // 0x80000000 negates to itself, which is the correct unsigned magnitude.
              mag_reg   <= bus.int_in[31] ? (~bus.int_in + 32'd1) : bus.int_in;
              exp_reg   <= EXP_START;
              state_reg <= NORM;
            end
          end
        end
        NORM: begin
          if (mag_reg[31]) begin
            state_reg <= ROUND;
          end else begin
            mag_reg <= {mag_reg[30:0], 1'b0};
            exp_reg <= exp_reg - 6'd1;
          end
        end
        ROUND: begin
          data_reg   <= {sign_reg, exp_round, round_sum[24:0]};
          status_reg <= (mag_reg[5] | sticky) ? STATUS_INEXACT : STATUS_EXACT;
          done_reg   <= 1'b1;
          state_reg  <= DONE;
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.data_out   = data_reg;
  assign bus.status_out = status_reg;

endmodule

// File: tb/tb_int_to_fpu.sv
// Randomised and directed checks of int_to_fpu against an arithmetic reference model.
`timescale 1ns/1ps
module tb_int_to_fpu;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  int_to_fpu_if bus ();

  int_to_fpu dut (
    .clock100KHz (clk),
    .reset       (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    n_checks++;
    if (obs === exp_val) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_val);
  endtask

  // Reference: value = mag rounded to 26 significant bits, expressed with plain integer arithmetic.
  function automatic void ref_model(input logic [31:0] v, output logic [31:0] data,
                                    output logic [3:0] st, output int lat);
    longint m, frac, mant, rem;
    int     p, sh, e;
    m = longint'($signed(v));
    if (m < 0) m = -m;
    if (m == 0) begin
      data = 32'd0;
      st   = 4'b0001;
      lat  = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (((m >> i) & 1) == 1) p = i;
    frac = m - (longint'(1) << p);
    rem  = 0;
    if (p <= 25) begin
      mant = frac << (25 - p);
    end else begin
      sh   = p - 25;
      mant = frac >> sh;
      rem  = frac & ((longint'(1) << sh) - 1);
      if (rem >= (longint'(1) << (sh - 1))) mant = mant + 1;
    end
    e = 31 + p;
    if (mant == (longint'(1) << 25)) begin
      mant = 0;
      e    = e + 1;
    end
    data = {v[31], 6'(e), 25'(mant)};
    st   = (rem != 0) ? 4'b0010 : 4'b0001;
    lat  = (31 - p) + 3;
  endfunction

  // One conversion; optionally pokes a different start mid-conversion, which must be ignored.
  task automatic run_conv(input logic [31:0] val, input bit poke, input bit has_const,
                          input logic [31:0] const_data, input logic [3:0] const_st);
    logic [31:0] exp_data;
    logic [3:0]  exp_st;
    int          exp_lat;
    int          edges;
    ref_model(val, exp_data, exp_st, exp_lat);
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.int_in = val;
    @(posedge clk); #1;
    edges      = 1;
    bus.start  = 1'b0;
    bus.int_in = $urandom;
    check_value("busy_after_start", 32'(bus.busy), 32'd1);
    while (!bus.done && edges < 60) begin
      if (poke && edges == 3) begin
        bus.start  = 1'b1;
        bus.int_in = 32'd5;
      end
      @(posedge clk); #1;
      edges++;
      bus.start = 1'b0;
    end
    check_value("done_seen", 32'(bus.done), 32'd1);
    check_value("latency", 32'(edges), 32'(exp_lat));
    check_value("data_out", bus.data_out, exp_data);
    check_value("status_out", 32'(bus.status_out), 32'(exp_st));
    if (has_const) begin
      check_value("data_table", bus.data_out, const_data);
      check_value("status_table", 32'(bus.status_out), 32'(const_st));
    end
    @(posedge clk); #1;
    check_value("done_one_cycle", 32'(bus.done), 32'd0);
    check_value("idle_busy", 32'(bus.busy), 32'd0);
    check_value("data_hold", bus.data_out, exp_data);
    $display("conv int_in=0x%08h -> data=0x%08h status=%04b latency=%0d", val, exp_data, exp_st, edges);
  endtask

  logic [31:0] dir_in   [8] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000003, 32'h00000000,
                                32'h7FFFFFFF, 32'h80000000, 32'h04000001, 32'h02000001};
  logic [31:0] dir_data [8] = '{32'h3E000000, 32'hBE000000, 32'h41000000, 32'h00000000,
                                32'h7C000000, 32'hFC000000, 32'h72000001, 32'h70000001};
  logic [3:0]  dir_st   [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                4'b0010, 4'b0001, 4'b0010, 4'b0001};

  initial begin
    bit done_seen;
    logic [31:0] r;
    n_checks   = 0;
    n_pass     = 0;
    bus.start  = 1'b0;
    bus.int_in = 32'd0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_busy", 32'(bus.busy), 32'd0);
    check_value("rst_done", 32'(bus.done), 32'd0);
    check_value("rst_data", bus.data_out, 32'd0);
    check_value("rst_status", 32'(bus.status_out), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_conv(dir_in[i], 1'b0, 1'b1, dir_data[i], dir_st[i]);

    // Start pulse while busy must not disturb the running conversion of 1.
    run_conv(32'h00000001, 1'b1, 1'b1, 32'h3E000000, 4'b0001);

    // Reset five cycles into converting 1: immediate abort, no done pulse.
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.int_in = 32'h00000001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_value("abort_busy", 32'(bus.busy), 32'd0);
    check_value("abort_data", bus.data_out, 32'd0);
    check_value("abort_status", 32'(bus.status_out), 32'd0);
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1'b1;
    end
    check_value("abort_no_done", 32'(done_seen), 32'd0);
    $display("reset abort checked");

    run_conv(32'h00000003, 1'b0, 1'b1, 32'h41000000, 4'b0001);

    // Random operands with a random right shift so every leading-zero count is exercised.
    for (int k = 0; k < 40; k++) begin
      r = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = -r;
      run_conv(r, 1'b0, 1'b0, 32'd0, 4'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
